// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: x/y counters plus a one-cycle registered, blanked colour/sync stage.
// Define VGA_TEST_PATTERN_EN to add a test_mode input that replaces the colour with 8 vertical bars.
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          H_POL    = 1'b0,
    parameter bit          V_POL    = 1'b0,
    parameter int unsigned COLOR_W  = 4,
    parameter int unsigned CNT_W    = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pix_en,
`ifdef VGA_TEST_PATTERN_EN
    input  logic               test_mode,
`endif
    input  logic [COLOR_W-1:0] r_in,
    input  logic [COLOR_W-1:0] g_in,
    input  logic [COLOR_W-1:0] b_in,
    output logic [CNT_W-1:0]   x,
    output logic [CNT_W-1:0]   y,
    output logic [COLOR_W-1:0] r_out,
    output logic [COLOR_W-1:0] g_out,
    output logic [COLOR_W-1:0] b_out,
    output logic               h_sync,
    output logic               v_sync,
    output logic               de,
    output logic               line_start,
    output logic               frame_start
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT_END  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT_END  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_START   = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END     = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_START   = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END     = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [CNT_W-1:0]   x_q, x_d, y_q, y_d;
    logic [COLOR_W-1:0] r_q, r_d, g_q, g_d, b_q, b_d;
    logic               hs_q, hs_d, vs_q, vs_d, de_q, de_d, ls_q, ls_d, fs_q, fs_d;
    logic [COLOR_W-1:0] src_r, src_g, src_b;

`ifdef VGA_TEST_PATTERN_EN
    localparam int unsigned      BAR_W   = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
    localparam logic [CNT_W-1:0] BAR_DIV = CNT_W'(BAR_W);
    logic [2:0] bar_k;
    assign bar_k = 3'(x_q / BAR_DIV);
`endif

    always_comb begin
        // NOTE: every combinational output is given a default first so no latch can be inferred.
        src_r = r_in;
        src_g = g_in;
        src_b = b_in;
`ifdef VGA_TEST_PATTERN_EN
        if (test_mode) begin
            src_r = {COLOR_W{bar_k[2]}};
            src_g = {COLOR_W{bar_k[1]}};
            src_b = {COLOR_W{bar_k[0]}};
        end
`endif
    end

    always_comb begin
        x_d = x_q + 1'b1;
        y_d = y_q;
        if (x_q == H_LAST) begin
            x_d = '0;
            y_d = (y_q == V_LAST) ? '0 : y_q + 1'b1;
        end

        // Output stage describes the pixel currently presented on x/y.
        de_d = (x_q < H_ACT_END) && (y_q < V_ACT_END);
        hs_d = ((x_q >= HS_START) && (x_q < HS_END)) ? H_POL : ~H_POL;
        vs_d = ((y_q >= VS_START) && (y_q < VS_END)) ? V_POL : ~V_POL;
        ls_d = (x_q == '0);
        fs_d = (x_q == '0) && (y_q == '0);
        r_d  = de_d ? src_r : '0;
        g_d  = de_d ? src_g : '0;
        b_d  = de_d ? src_b : '0;
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
        if (rst) begin
            x_q  <= '0;
            y_q  <= '0;
            r_q  <= '0;
            g_q  <= '0;
            b_q  <= '0;
            de_q <= 1'b0;
            hs_q <= ~H_POL;
            vs_q <= ~V_POL;
            ls_q <= 1'b0;
            fs_q <= 1'b0;
        end else if (pix_en) begin
            x_q  <= x_d;
            y_q  <= y_d;
            r_q  <= r_d;
            g_q  <= g_d;
            b_q  <= b_d;
            de_q <= de_d;
            hs_q <= hs_d;
            vs_q <= vs_d;
            ls_q <= ls_d;
            fs_q <= fs_d;
        end
    end

    assign x           = x_q;
    assign y           = y_q;
    assign r_out       = r_q;
    assign g_out       = g_q;
    assign b_out       = b_q;
    assign h_sync      = hs_q;
    assign v_sync      = vs_q;
    assign de          = de_q;
    assign line_start  = ls_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomised bench for vga_timing_gen on a reduced raster, checked against a position-arithmetic model.
// Exercises the colour-bar generator too when VGA_TEST_PATTERN_EN is defined.
module tb_vga_timing_gen;

    localparam int HA = 16, HF = 4, HS = 6, HB = 6;
    localparam int VA = 8,  VF = 2, VS = 2, VB = 3;
    localparam bit HP = 1'b0, VP = 1'b1;
    localparam int CW = 4, NW = 6;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FT = HT * VT;

    logic          clk = 1'b0;
    logic          rst, pix_en;
    logic [CW-1:0] r_in, g_in, b_in;
    logic [NW-1:0] x, y;
    logic [CW-1:0] r_out, g_out, b_out;
    logic          h_sync, v_sync, de, line_start, frame_start;
    logic          tm = 1'b0;
`ifdef VGA_TEST_PATTERN_EN
    logic          test_mode = 1'b0;
`endif

    always #5 clk = ~clk;

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .H_POL(HP), .V_POL(VP), .COLOR_W(CW), .CNT_W(NW)
    ) dut (
        .clk(clk), .rst(rst), .pix_en(pix_en),
`ifdef VGA_TEST_PATTERN_EN
        .test_mode(test_mode),
`endif
        .r_in(r_in), .g_in(g_in), .b_in(b_in),
        .x(x), .y(y), .r_out(r_out), .g_out(g_out), .b_out(b_out),
        .h_sync(h_sync), .v_sync(v_sync), .de(de),
        .line_start(line_start), .frame_start(frame_start)
    );

    typedef struct packed {
        logic [NW-1:0] x;
        logic [NW-1:0] y;
        logic [CW-1:0] r;
        logic [CW-1:0] g;
        logic [CW-1:0] b;
        logic          hs;
        logic          vs;
        logic          de;
        logic          ls;
        logic          fs;
    } view_t;

    view_t obs_v, exp_v;
    int    n_en;
    int    checks = 0;
    int    passes = 0;

    assign obs_v = {x, y, r_out, g_out, b_out, h_sync, v_sync, de, line_start, frame_start};

    function automatic string show(input view_t v);
        return $sformatf("x=%0d y=%0d rgb=%h%h%h hs=%b vs=%b de=%b ls=%b fs=%b",
                         v.x, v.y, v.r, v.g, v.b, v.hs, v.vs, v.de, v.ls, v.fs);
    endfunction

    function automatic view_t reset_view();
        view_t v;
        v    = '0;
        v.hs = !HP;
        v.vs = !VP;
        return v;
    endfunction

    // Outputs after the (m+1)-th enabled edge since reset: they describe raster position m.
    function automatic view_t model_edge(input int m, input logic [CW-1:0] ri, input logic [CW-1:0] gi,
                                         input logic [CW-1:0] bi, input logic tmode);
        view_t v;
        int px, py, k;
        px   = m % HT;
        py   = (m / HT) % VT;
        v.x  = NW'((m + 1) % HT);
        v.y  = NW'(((m + 1) / HT) % VT);
        v.de = (px < HA) && (py < VA);
        v.hs = (px >= HA + HF && px < HA + HF + HS) ? HP : !HP;
        v.vs = (py >= VA + VF && py < VA + VF + VS) ? VP : !VP;
        v.ls = (px == 0);
        v.fs = (px == 0) && (py == 0);
        if (tmode) begin
            k  = px / (HA / 8);
            ri = ((k & 4) != 0) ? '1 : '0;
            gi = ((k & 2) != 0) ? '1 : '0;
            bi = ((k & 1) != 0) ? '1 : '0;
        end
        v.r = v.de ? ri : '0;
        v.g = v.de ? gi : '0;
        v.b = v.de ? bi : '0;
        return v;
    endfunction

    // Drives one clock of stimulus and advances the model; outputs are sampled 1 ns after the edge.
    task automatic step(input logic rst_v, input logic en_v,
                        input logic [CW-1:0] ri, input logic [CW-1:0] gi, input logic [CW-1:0] bi);
        rst    = rst_v;
        pix_en = en_v;
        r_in   = ri;
        g_in   = gi;
        b_in   = bi;
        @(posedge clk);
        if (rst_v) begin
            exp_v = reset_view();
            n_en  = 0;
        end else if (en_v) begin
            exp_v = model_edge(n_en, ri, gi, bi, tm);
            n_en++;
        end
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4; i++) begin
            step(1'b1, (i != 2), CW'($urandom), CW'($urandom), CW'($urandom));
            checks++;
            if (obs_v !== exp_v) $display("FAIL reset_hold[%0d]: got %s, expected %s", i, show(obs_v), show(exp_v));
            else passes++;
        end
        step(1'b0, 1'b1, CW'($urandom), CW'($urandom), CW'($urandom));
        checks++;
        if ({line_start, frame_start} !== 2'b11)
            $display("FAIL first_strobes: got ls=%b fs=%b, expected ls=1 fs=1", line_start, frame_start);
        else passes++;
        checks++;
        if (obs_v !== exp_v) $display("FAIL first_pixel: got %s, expected %s", show(obs_v), show(exp_v));
        else passes++;
    endtask

    task automatic test_free_run();
        int n_de, n_hs, n_vs, n_fs, n_ls, n_err;
        n_de = 0; n_hs = 0; n_vs = 0; n_fs = 0; n_ls = 0; n_err = 0;
        step(1'b1, 1'b1, '0, '0, '0);
        for (int i = 0; i < FT; i++) begin
            step(1'b0, 1'b1, CW'($urandom), CW'($urandom), CW'($urandom));
            if (obs_v !== exp_v) begin
                n_err++;
                if (n_err <= 5) $display("FAIL free_run[%0d]: got %s, expected %s", i, show(obs_v), show(exp_v));
            end
            n_de += int'(de);
            n_hs += int'(h_sync == HP);
            n_vs += int'(v_sync == VP);
            n_fs += int'(frame_start);
            n_ls += int'(line_start);
        end
        checks++;
        if (n_err != 0) $display("FAIL free_run_cycles: got %0d bad cycles, expected 0", n_err);
        else passes++;
        checks++;
        if (n_de != HA * VA) $display("FAIL de_count: got %0d, expected %0d", n_de, HA * VA);
        else passes++;
        checks++;
        if (n_hs != HS * VT) $display("FAIL hsync_count: got %0d, expected %0d", n_hs, HS * VT);
        else passes++;
        checks++;
        if (n_vs != VS * HT) $display("FAIL vsync_count: got %0d, expected %0d", n_vs, VS * HT);
        else passes++;
        checks++;
        if (n_fs != 1 || n_ls != VT) $display("FAIL strobe_count: got fs=%0d ls=%0d, expected fs=1 ls=%0d", n_fs, n_ls, VT);
        else passes++;
    endtask

    task automatic test_const_colour();
        int n_err;
        n_err = 0;
        for (int i = 0; i < FT; i++) begin
            step(1'b0, 1'b1, 4'hF, 4'hA, 4'h5);
            if (obs_v !== exp_v || {r_out, g_out, b_out} !== (de ? 12'hFA5 : 12'h000)) begin
                n_err++;
                if (n_err <= 5) $display("FAIL const_colour[%0d]: got %s, expected %s", i, show(obs_v), show(exp_v));
            end
        end
        checks++;
        if (n_err != 0) $display("FAIL const_colour_cycles: got %0d bad cycles, expected 0", n_err);
        else passes++;
    endtask

    task automatic test_toggle_enable();
        int n_err, run, n_runs, n_bad_runs;
        n_err = 0; run = 0; n_runs = 0; n_bad_runs = 0;
        for (int i = 0; i < 4 * FT; i++) begin
            step(1'b0, logic'(i % 2 == 0), CW'($urandom), CW'($urandom), CW'($urandom));
            if (obs_v !== exp_v) begin
                n_err++;
                if (n_err <= 5) $display("FAIL toggle[%0d]: got %s, expected %s", i, show(obs_v), show(exp_v));
            end
            if (frame_start) run++;
            else if (run != 0) begin
                n_runs++;
                if (run != 2) n_bad_runs++;
                run = 0;
            end
        end
        checks++;
        if (n_err != 0) $display("FAIL toggle_cycles: got %0d bad cycles, expected 0", n_err);
        else passes++;
        checks++;
        if (n_runs != 2 || n_bad_runs != 0)
            $display("FAIL frame_start_width: got %0d pulses (%0d not 2 clocks wide), expected 2 pulses of 2 clocks",
                     n_runs, n_bad_runs);
        else passes++;
    endtask

    task automatic test_random_enable();
        int n_err;
        n_err = 0;
        for (int i = 0; i < 600; i++) begin
            step(1'b0, logic'($urandom_range(0, 1)), CW'($urandom), CW'($urandom), CW'($urandom));
            if (obs_v !== exp_v) begin
                n_err++;
                if (n_err <= 5) $display("FAIL random_en[%0d]: got %s, expected %s", i, show(obs_v), show(exp_v));
            end
        end
        checks++;
        if (n_err != 0) $display("FAIL random_en_cycles: got %0d bad cycles, expected 0", n_err);
        else passes++;
    endtask

    task automatic test_mid_reset();
        int n_err;
        n_err = 0;
        step(1'b1, 1'b1, '0, '0, '0);
        for (int i = 0; i < 5 * HT + 20; i++) step(1'b0, 1'b1, CW'($urandom), CW'($urandom), CW'($urandom));
        checks++;
        if (x !== NW'(20) || y !== NW'(5)) $display("FAIL mid_position: got x=%0d y=%0d, expected x=20 y=5", x, y);
        else passes++;
        step(1'b1, 1'b1, CW'($urandom), CW'($urandom), CW'($urandom));
        checks++;
        if (obs_v !== exp_v) $display("FAIL mid_reset: got %s, expected %s", show(obs_v), show(exp_v));
        else passes++;
        for (int i = 0; i < FT; i++) begin
            step(1'b0, 1'b1, CW'($urandom), CW'($urandom), CW'($urandom));
            if (obs_v !== exp_v) begin
                n_err++;
                if (n_err <= 5) $display("FAIL restart[%0d]: got %s, expected %s", i, show(obs_v), show(exp_v));
            end
        end
        checks++;
        if (n_err != 0) $display("FAIL restart_cycles: got %0d bad cycles, expected 0", n_err);
        else passes++;
    endtask

`ifdef VGA_TEST_PATTERN_EN
    task automatic test_pattern();
        int n_err;
        n_err     = 0;
        tm        = 1'b1;
        test_mode = 1'b1;
        step(1'b1, 1'b1, '0, '0, '0);
        for (int i = 0; i < FT; i++) begin
            step(1'b0, 1'b1, CW'($urandom), CW'($urandom), CW'($urandom));
            if (obs_v !== exp_v) begin
                n_err++;
                if (n_err <= 5) $display("FAIL pattern[%0d]: got %s, expected %s", i, show(obs_v), show(exp_v));
            end
        end
        tm        = 1'b0;
        test_mode = 1'b0;
        checks++;
        if (n_err != 0) $display("FAIL pattern_cycles: got %0d bad cycles, expected 0", n_err);
        else passes++;
    endtask
`endif

    initial begin
        rst    = 1'b1;
        pix_en = 1'b0;
        r_in   = '0;
        g_in   = '0;
        b_in   = '0;
        n_en   = 0;
        exp_v  = reset_view();
        test_reset();
        test_free_run();
        test_const_colour();
        test_toggle_enable();
        test_random_enable();
        test_mid_reset();
`ifdef VGA_TEST_PATTERN_EN
        test_pattern();
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
